// File: rtl/wrr_sched.sv
// ---------------------------------------------------------------------------
// WrrSched: three-channel weighted round-robin burst scheduler.
//
// A channel that wins arbitration owns the downstream port for a burst of up
// to Weight[ch] beats (a weight of 0 counts as 1). A beat moves on every
// cycle where i_DataGrant_D, the grant and the channel's request are all high.
// The burst ends when its last beat moves or when the owner drops its request.
// Arbitration then moves straight to the next channel with no idle cycle.
//
// Ports:
//   CLK            in   clock, rising edge
//   ASynReset_N    in   asynchronous active-low reset
//   i_Req[2:0]     in   per-channel request (bit0=A, bit1=B, bit2=C)
//   i_Weight_A/B/C in   per-channel burst quota, WIDTH_W bits each
//   i_DataGrant_D  in   downstream ready
//   o_Grant[2:0]   out  registered one-hot grant, or all-zero when idle
//   o_Busy         out  high while a burst is being served
//   o_CurCh[1:0]   out  granted channel index, 0 when idle
//   o_Quota        out  beats left in the current burst, 0 when idle
// ---------------------------------------------------------------------------
module wrr_sched #(
  parameter int WIDTH_W = 4
) (
  input  logic               CLK,
  input  logic               ASynReset_N,
  input  logic [2:0]         i_Req,
  input  logic [WIDTH_W-1:0] i_Weight_A,
  input  logic [WIDTH_W-1:0] i_Weight_B,
  input  logic [WIDTH_W-1:0] i_Weight_C,
  input  logic               i_DataGrant_D,
  output logic [2:0]         o_Grant,
  output logic               o_Busy,
  output logic [1:0]         o_CurCh,
  output logic [WIDTH_W-1:0] o_Quota
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [WIDTH_W-1:0] QUOTA_ONE = WIDTH_W'(1);

  state_e             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [1:0]         cur_q, cur_d;
  logic [1:0]         last_q, last_d;
  logic [WIDTH_W-1:0] quota_q, quota_d;

  logic [1:0]         cand1, cand2, sel;
  logic               anyReq, xfer, relBurst, doArb;
  logic [WIDTH_W-1:0] selWeight, loadQuota;

  function automatic logic [1:0] nextCh(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Search order is last+1, last+2, last. Inside a burst last_q always equals
  // cur_q, so this one search serves both the idle start and the release
  // hand-over. The current owner is checked last, which means it only wins
  // again when nobody else is requesting.
  always_comb begin
    cand1  = nextCh(last_q);
    cand2  = nextCh(cand1);
    anyReq = |i_Req;
    if (i_Req[cand1]) begin
      sel = cand1;
    end else if (i_Req[cand2]) begin
      sel = cand2;
    end else begin
      sel = last_q;
    end
  end

  // The weight is sampled only when a burst is loaded. Zero is promoted to
  // one so that a granted channel always gets at least one beat.
  always_comb begin
    case (sel)
      2'd0:    selWeight = i_Weight_A;
      2'd1:    selWeight = i_Weight_B;
      default: selWeight = i_Weight_C;
    endcase
    loadQuota = (selWeight == '0) ? QUOTA_ONE : selWeight;
  end

  // Next-state logic. A final beat and a dropped request in the same cycle
  // form one release. The reload path runs before any decrement, so the
  // quota can never wrap below zero.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cur_d   = cur_q;
    quota_d = quota_q;
    last_d  = last_q;

    xfer     = i_DataGrant_D & i_Req[cur_q];
    relBurst = (state_q == GRANT) &&
               (!i_Req[cur_q] || (xfer && (quota_q == QUOTA_ONE)));
    doArb    = (state_q == IDLE) || relBurst;

    if (doArb) begin
      if (anyReq) begin
        state_d = GRANT;
        grant_d = 3'b001 << sel;
        cur_d   = sel;
        quota_d = loadQuota;
        last_d  = sel;
      end else begin
        state_d = IDLE;
        grant_d = 3'b000;
        cur_d   = 2'd0;
        quota_d = '0;
      end
    end else if (xfer) begin
      quota_d = quota_q - QUOTA_ONE;
    end
  end

  // State registers. Reset points last_q at C so that A is searched first.
  always_ff @(posedge CLK or negedge ASynReset_N) begin
    if (!ASynReset_N) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      cur_q   <= 2'd0;
      quota_q <= '0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cur_q   <= cur_d;
      quota_q <= quota_d;
      last_q  <= last_d;
    end
  end

  assign o_Grant = grant_q;
  assign o_Busy  = (state_q == GRANT);
  assign o_CurCh = cur_q;
  assign o_Quota = quota_q;

endmodule
